// File: rtl/spi_host_master_if.sv
// ----------------------------------------------------------------------------
// spi_host_master_if
//   Request/response bundle between the test-setup control logic and the
//   spi_host_master SPI initiator.
//
//   Signals
//     req_valid    request present (driven by the requester)
//     req_ready    host idle; request taken when req_valid & req_ready
//     req_rd_wr    1 = read, 0 = write
//     req_address  target address, ADDR_WIDTH bits
//     req_wr_data  write data, DATA_WIDTH bits (ignored on reads)
//     rsp_valid    one-cycle pulse at the end of every frame
//     rsp_rd_data  read data, valid with rsp_valid on reads
//     busy         high from the accept cycle until req_ready returns
//
//   Modports
//     master  the requester (control logic / testbench)
//     slave   the SPI host itself
// ----------------------------------------------------------------------------
interface spi_host_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_rd_wr;
   logic [ADDR_WIDTH-1:0] req_address;
   logic [DATA_WIDTH-1:0] req_wr_data;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rd_data;
   logic                  busy;

   modport master (
      output req_valid,
      output req_rd_wr,
      output req_address,
      output req_wr_data,
      input  req_ready,
      input  rsp_valid,
      input  rsp_rd_data,
      input  busy
   );

   modport slave (
      input  req_valid,
      input  req_rd_wr,
      input  req_address,
      input  req_wr_data,
      output req_ready,
      output rsp_valid,
      output rsp_rd_data,
      output busy
   );

endinterface

// File: rtl/spi_host_master.sv
// ----------------------------------------------------------------------------
// spi_host_master
//   sys_clk-domain SPI initiator. Each accepted request is turned into one
//   SPI mode-0 frame, MSB first: {rd_wr, address, wr_data}, where wr_data is
//   sent as zeros on reads. For reads, the device's data bits sampled on miso
//   are returned on rsp_rd_data together with the one-cycle rsp_valid pulse.
//
//   Frame timing (all in sys_clk cycles, CLK_DIV per sclk half-period):
//     SETUP  CLK_DIV          cs_n low, first bit on mosi
//     SHIFT  2*CLK_DIV per bit, N = 1 + ADDR_WIDTH + DATA_WIDTH bits
//     HOLD   CLK_DIV          mosi back to 0, cs_n still low
//     GAP    CLK_DIV          cs_n high, rsp_valid pulses on the first cycle
//
//   Ports
//     sys_clk      system clock, all logic on its rising edge
//     rst          synchronous active-high reset
//     bus          spi_host_master_if.slave request/response bundle
//     sclk         SPI clock, idles low
//     cs_n         chip select, active low, idles high
//     mosi         host-to-device data
//     miso         device-to-host data
//     lb_mismatch  (SPI_HOST_LOOPBACK_EN only) sticky flag, mosi moved
//                  while sclk was high
//
//   Build option
//     SPI_HOST_LOOPBACK_EN  ignore miso and sample the registered mosi
//                           instead, for bring-up without a device.
// ----------------------------------------------------------------------------
module spi_host_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CLK_DIV    = 4
) (
   input  logic                   sys_clk,
   input  logic                   rst,
   spi_host_master_if.slave       bus,
   output logic                   sclk,
   output logic                   cs_n,
   output logic                   mosi,
   input  logic                   miso
`ifdef SPI_HOST_LOOPBACK_EN
   ,
   output logic                   lb_mismatch
`endif
);

   localparam int N     = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(N);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(ADDR_WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   state_t                 state;
   logic [DIV_W-1:0]       div_cnt;
   logic [CNT_W-1:0]       bit_cnt;
   logic [N-2:0]           shift_reg;
   logic [DATA_WIDTH-1:0]  capture;
   logic                   is_read;

   logic                   div_end;
   logic                   sample_bit;
   logic [N-1:0]           frame_in;

   // The divider wraps every CLK_DIV cycles; every timed step of the frame
   // (setup, each sclk half-period, hold, gap) ends on that wrap.
   assign div_end = (div_cnt == DIV_LAST);

   // The outgoing frame; the data field is forced to zero on reads.
   assign frame_in = {bus.req_rd_wr,
                      bus.req_address,
                      bus.req_rd_wr ? {DATA_WIDTH{1'b0}} : bus.req_wr_data};

`ifdef SPI_HOST_LOOPBACK_EN
   logic lb_ref;
   logic unused_miso;

   // In loopback the device pin is deliberately left unconnected and the
   // sample point sees our own registered mosi.
   assign unused_miso = miso;
   assign sample_bit  = mosi;
`else
   assign sample_bit  = miso;
`endif

   // Single FSM holding every output register. mosi always shows the bit
   // currently on the wire while shift_reg holds the bits still to come, so
   // advancing on a falling sclk edge is just "take the next MSB".
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state           <= IDLE;
         div_cnt         <= '0;
         bit_cnt         <= '0;
         shift_reg       <= '0;
         capture         <= '0;
         is_read         <= 1'b0;
         sclk            <= 1'b0;
         cs_n            <= 1'b1;
         mosi            <= 1'b0;
         bus.req_ready   <= 1'b1;
         bus.busy        <= 1'b0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rd_data <= '0;
      end else begin
         bus.rsp_valid <= 1'b0;

         if (state != IDLE) begin
            div_cnt <= div_end ? '0 : div_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  shift_reg     <= frame_in[N-2:0];
                  mosi          <= frame_in[N-1];
                  is_read       <= bus.req_rd_wr;
                  cs_n          <= 1'b0;
                  bus.req_ready <= 1'b0;
                  bus.busy      <= 1'b1;
                  div_cnt       <= '0;
                  bit_cnt       <= '0;
                  state         <= SETUP;
               end
            end

            SETUP: begin
               if (div_end) begin
                  state <= SHIFT;
               end
            end

            SHIFT: begin
               if (div_end) begin
                  if (!sclk) begin
                     // Rising edge: sample. Only the data-field bits are
                     // kept; command and address bits of miso are ignored.
                     sclk <= 1'b1;
                     if (bit_cnt >= CAP_FIRST) begin
                        capture <= {capture[DATA_WIDTH-2:0], sample_bit};
                     end
                  end else begin
                     // Falling edge: move to the next bit, or finish.
                     sclk      <= 1'b0;
                     shift_reg <= {shift_reg[N-3:0], 1'b0};
                     if (bit_cnt == BIT_LAST) begin
                        mosi  <= 1'b0;
                        state <= HOLD;
                     end else begin
                        mosi    <= shift_reg[N-2];
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
            end

            HOLD: begin
               if (div_end) begin
                  cs_n          <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  if (is_read) begin
                     bus.rsp_rd_data <= capture;
                  end
                  state <= GAP;
               end
            end

            GAP: begin
               if (div_end) begin
                  bus.req_ready <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SPI_HOST_LOOPBACK_EN
   // Sticky loopback sanity flag: remember the bit presented at each rising
   // sclk edge and flag any cycle of the high phase where mosi differs.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         lb_ref      <= 1'b0;
         lb_mismatch <= 1'b0;
      end else begin
         if (state == SHIFT && !sclk && div_end) begin
            lb_ref <= mosi;
         end
         if (state == SHIFT && sclk && (mosi != lb_ref)) begin
            lb_mismatch <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_spi_host_master.sv
// ----------------------------------------------------------------------------
// tb_spi_host_master
//   Directed bench for spi_host_master. dut runs with 8-bit address/data and
//   CLK_DIV=2 against a small mode-0 device model; dut2 runs with CLK_DIV=1
//   and miso tied high. Expected frames and responses are queued when a
//   request is driven and compared when the monitor sees the frame end.
// ----------------------------------------------------------------------------
module tb_spi_host_master;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int N  = 1 + AW + DW;

`ifdef SPI_HOST_LOOPBACK_EN
   localparam bit LOOPBACK = 1'b1;
`else
   localparam bit LOOPBACK = 1'b0;
`endif

   logic sys_clk = 1'b0;
   logic rst     = 1'b1;

   always #5 sys_clk = ~sys_clk;

   logic sclk, cs_n, mosi;
   logic miso = 1'b0;
   logic sclk2, cs_n2, mosi2;
   logic miso2;
   assign miso2 = 1'b1;

`ifdef SPI_HOST_LOOPBACK_EN
   logic lb_mismatch, lb_mismatch2;
`endif

   spi_host_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
   spi_host_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

   spi_host_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(2)) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus1),
      .sclk    (sclk),
      .cs_n    (cs_n),
      .mosi    (mosi),
      .miso    (miso)
`ifdef SPI_HOST_LOOPBACK_EN
      ,
      .lb_mismatch (lb_mismatch)
`endif
   );

   spi_host_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(1)) dut2 (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus2),
      .sclk    (sclk2),
      .cs_n    (cs_n2),
      .mosi    (mosi2),
      .miso    (miso2)
`ifdef SPI_HOST_LOOPBACK_EN
      ,
      .lb_mismatch (lb_mismatch2)
`endif
   );

   typedef struct {
      logic [N-1:0]  bits;
      int            nbits;
      int            low;
      bit            rsp_seen;
      logic [DW-1:0] rsp_data;
      int            end_cyc;
   } frame_t;

   typedef struct {
      logic [N-1:0]  bits;
      logic [DW-1:0] rsp;
   } exp_t;

   frame_t        frame_q[$];
   exp_t          exp_q[$];
   int            accept_q[$];
   logic [DW-1:0] dev_q[$];

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] last_rd = '0;

   int            cyc = 0;
   int            rsp_count = 0;
   int            high_run = 0;
   int            last_gap = 0;
   int            dev_bit = 0;
   logic [DW-1:0] dev_cur = '0;
   logic          prev_cs = 1'b1;
   logic          prev_sclk = 1'b0;
   frame_t        cur;

   // Monitor and device model for dut, sampled on the falling sys_clk edge.
   // The device presents its data bits MSB first on the data-field bits and
   // drives 0 elsewhere; mosi is recorded at each sclk rise.
   always @(negedge sys_clk) begin
      cyc++;
      if (bus1.req_valid && bus1.req_ready) accept_q.push_back(cyc);
      if (bus1.rsp_valid) rsp_count++;
      if (cs_n === 1'b0) begin
         if (prev_cs) begin
            last_gap     = high_run;
            cur.bits     = '0;
            cur.nbits    = 0;
            cur.low      = 0;
            dev_bit      = 0;
            dev_cur      = (dev_q.size() > 0) ? dev_q.pop_front() : '0;
         end
         cur.low++;
         high_run = 0;
         if (sclk && !prev_sclk) begin
            cur.bits = {cur.bits[N-2:0], mosi};
            cur.nbits++;
            dev_bit++;
         end
      end else begin
         high_run++;
         if (!prev_cs && cs_n === 1'b1) begin
            cur.rsp_seen = bus1.rsp_valid;
            cur.rsp_data = bus1.rsp_rd_data;
            cur.end_cyc  = cyc;
            frame_q.push_back(cur);
         end
      end
      miso      = (dev_bit >= AW + 1 && dev_bit < N) ? dev_cur[N-1-dev_bit] : 1'b0;
      prev_cs   = (cs_n === 1'b0) ? 1'b0 : 1'b1;
      prev_sclk = (sclk === 1'b1);
   end

   // One comparison: counts it, and on a miss counts the failure and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one request on dut (sel2=0) or dut2 (sel2=1) and returns one
   // cycle after it was accepted, leaving req_valid high. For dut the
   // expected frame and response are queued here.
   task automatic applyStimulus(input bit sel2, input logic rd,
                                input logic [AW-1:0] addr,
                                input logic [DW-1:0] data,
                                input logic [DW-1:0] dev);
      exp_t e;
      bit   ok;
      if (!sel2) begin
         e.bits = {rd, addr, rd ? {DW{1'b0}} : data};
         if (rd) last_rd = LOOPBACK ? '0 : dev;
         e.rsp = last_rd;
         exp_q.push_back(e);
         dev_q.push_back(dev);
         bus1.req_valid   = 1'b1;
         bus1.req_rd_wr   = rd;
         bus1.req_address = addr;
         bus1.req_wr_data = data;
      end else begin
         bus2.req_valid   = 1'b1;
         bus2.req_rd_wr   = rd;
         bus2.req_address = addr;
         bus2.req_wr_data = data;
      end
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (sel2 ? bus2.req_ready : bus1.req_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge sys_clk); #1;
      end
      checkOutput("accept_wait", ok, 1);
      @(posedge sys_clk); #1;
   endtask

   // Waits (bounded) for the next finished dut frame and scores it.
   task automatic checkFrame(input string tag, output int acc);
      frame_t f;
      exp_t   e;
      bit     got;
      got = 1'b0;
      acc = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         if (frame_q.size() > 0) got = 1'b1;
         else @(negedge sys_clk);
      end
      checkOutput({tag, "_seen"}, got, 1);
      if (got) begin
         f   = frame_q.pop_front();
         e   = exp_q.pop_front();
         acc = accept_q.pop_front();
         checkOutput({tag, "_mosi"},     f.bits, e.bits);
         checkOutput({tag, "_nbits"},    f.nbits, N);
         checkOutput({tag, "_cs_low"},   f.low, 72);
         checkOutput({tag, "_rsp_seen"}, f.rsp_seen, 1);
         checkOutput({tag, "_rsp_data"}, f.rsp_data, e.rsp);
         checkOutput({tag, "_latency"},  f.end_cyc - acc, 73);
      end
      @(posedge sys_clk); #1;
   endtask

   initial begin
      int            acc1, acc2;
      bit            got;
      frame_t        f;
      int            lat, rise_cnt, first_rise, second_rise;
      logic          prev2;
      logic [DW-1:0] rd2;

      bus1.req_valid = 1'b0; bus1.req_rd_wr = 1'b0;
      bus1.req_address = '0; bus1.req_wr_data = '0;
      bus2.req_valid = 1'b0; bus2.req_rd_wr = 1'b0;
      bus2.req_address = '0; bus2.req_wr_data = '0;

      repeat (3) @(posedge sys_clk);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_req_ready",   bus1.req_ready, 1);
      checkOutput("rst_rsp_valid",   bus1.rsp_valid, 0);
      checkOutput("rst_rsp_rd_data", bus1.rsp_rd_data, 0);
      checkOutput("rst_busy",        bus1.busy, 0);
      checkOutput("rst_sclk",        sclk, 0);
      checkOutput("rst_cs_n",        cs_n, 1);
      checkOutput("rst_mosi",        mosi, 0);
      checkOutput("rst_cs_n2",       cs_n2, 1);
      rst = 1'b0;
      @(posedge sys_clk); #1;

      $display("[TB] write A5/3C");
      applyStimulus(1'b0, 1'b0, 8'hA5, 8'h3C, 8'h00);
      checkOutput("wr_busy", bus1.busy, 1);
      checkOutput("wr_ready_low", bus1.req_ready, 0);
      bus1.req_valid   = 1'b0;
      bus1.req_address = 8'($urandom);
      bus1.req_wr_data = 8'($urandom);
      checkFrame("write1", acc1);

      $display("[TB] read 0F, device C3");
      applyStimulus(1'b0, 1'b1, 8'h0F, 8'hFF, 8'hC3);
      bus1.req_valid = 1'b0;
      bus1.req_rd_wr = 1'b0;
      checkFrame("read1", acc1);

      $display("[TB] back-to-back read 33 then write 81/7E");
      applyStimulus(1'b0, 1'b1, 8'h33, 8'h00, 8'h5A);
      applyStimulus(1'b0, 1'b0, 8'h81, 8'h7E, 8'hE7);
      bus1.req_valid = 1'b0;
      checkFrame("b2b_first", acc1);
      checkFrame("b2b_second", acc2);
      checkOutput("b2b_accept_spacing", acc2 - acc1, 75);
      checkOutput("b2b_cs_high_gap", last_gap, 3);

      $display("[TB] reset mid-read");
      applyStimulus(1'b0, 1'b1, 8'h55, 8'h00, 8'hFF);
      bus1.req_valid = 1'b0;
      repeat (29) begin @(posedge sys_clk); #1; end
      rst = 1'b1;
      @(posedge sys_clk); #1;
      rst = 1'b0;
      checkOutput("abort_cs_n",      cs_n, 1);
      checkOutput("abort_sclk",      sclk, 0);
      checkOutput("abort_req_ready", bus1.req_ready, 1);
      checkOutput("abort_busy",      bus1.busy, 0);
      checkOutput("abort_rsp_valid", bus1.rsp_valid, 0);
      checkOutput("abort_rsp_data",  bus1.rsp_rd_data, 0);
      last_rd = '0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         if (frame_q.size() > 0) got = 1'b1;
         else @(negedge sys_clk);
      end
      checkOutput("abort_frame_seen", got, 1);
      if (got) begin
         f = frame_q.pop_front();
         void'(exp_q.pop_front());
         void'(accept_q.pop_front());
         checkOutput("abort_no_rsp", f.rsp_seen, 0);
      end
      @(posedge sys_clk); #1;
      applyStimulus(1'b0, 1'b1, 8'hF0, 8'h00, 8'h3C);
      bus1.req_valid = 1'b0;
      checkFrame("after_abort", acc1);

      $display("[TB] CLK_DIV=1 read, miso tied high");
      applyStimulus(1'b1, 1'b1, 8'hAA, 8'h00, 8'h00);
      bus2.req_valid = 1'b0;
      lat = 0; rise_cnt = 0; first_rise = -1; second_rise = -1;
      prev2 = 1'b0; rd2 = '0;
      for (int k = 1; k <= 200; k++) begin
         if (sclk2 && !prev2) begin
            rise_cnt++;
            if (first_rise < 0) first_rise = k;
            else if (second_rise < 0) second_rise = k;
         end
         prev2 = sclk2;
         if (bus2.rsp_valid) begin
            lat = k;
            rd2 = bus2.rsp_rd_data;
            break;
         end
         @(posedge sys_clk); #1;
      end
      checkOutput("div1_latency",     lat, 37);
      checkOutput("div1_sclk_pulses", rise_cnt, 17);
      checkOutput("div1_sclk_period", second_rise - first_rise, 2);
      checkOutput("div1_rsp_data",    rd2, LOOPBACK ? 8'h00 : 8'hFF);
      checkOutput("div1_cs_n_end",    cs_n2, 1);

`ifdef SPI_HOST_LOOPBACK_EN
      checkOutput("lb_mismatch",  lb_mismatch, 0);
      checkOutput("lb_mismatch2", lb_mismatch2, 0);
`endif

      repeat (4) begin @(posedge sys_clk); #1; end
      checkOutput("rsp_pulse_count", rsp_count, 5);
      checkOutput("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_host_master.md
Name: spi_host_master

Overview:
- sys_clk-domain SPI initiator; drives the SPI frames that spi device blocks receive and synchronize.
- Converts a single-word request (rd_wr, address, wr_data) into one SPI mode-0 frame, MSB first.
- For reads, returns the data sampled on miso through a one-cycle response strobe.
- Sits between the test-setup register/control logic and the DUT SPI pins.

Parameters:
- ADDR_WIDTH, 32: address bits per frame.
- DATA_WIDTH, 32: data bits per frame.
- CLK_DIV, 4: sys_clk cycles per sclk half-period, ≥1.
- Derived N = 1 + ADDR_WIDTH + DATA_WIDTH: total bits per frame.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; request accepted when req_valid & req_ready.
- req_rd_wr  in  1  1 = read, 0 = write.
- req_address  in  ADDR_WIDTH  target address.
- req_wr_data  in  DATA_WIDTH  write data; ignored on reads.
- rsp_valid  out  1  one-cycle pulse at end of every frame.
- rsp_rd_data  out  DATA_WIDTH  read data; valid at rsp_valid for reads.
- busy  out  1  high from the accept cycle until req_ready reasserts.
- sclk  out  1  SPI clock; idle low.
- cs_n  out  1  chip select, active low; idle high.
- mosi  out  1  host-to-device data.
- miso  in  1  device-to-host data.

Behaviour:
- Reset (synchronous, rst=1 at sys_clk edge):
  - All outputs registered.
  - After reset: req_ready=1, rsp_valid=0, rsp_rd_data=0, busy=0, sclk=0, cs_n=1, mosi=0.
  - Reset mid-frame aborts the frame immediately: no rsp_valid, cs_n returns high the next cycle.
- FSM states IDLE, SETUP, SHIFT, HOLD, GAP; a divider counter counts 0..CLK_DIV-1 in every non-IDLE state.
- IDLE -> SETUP on accept:
  - Latch frame {rd_wr, address, wr_data}; on reads, wr_data is replaced by zeros.
  - req_ready drops and busy rises in the cycle after accept.
  - cs_n drops and mosi shows frame MSB in that same cycle.
- SETUP lasts CLK_DIV cycles -> SHIFT.
- SHIFT (N bits, each bit 2*CLK_DIV cycles):
  - sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - miso is sampled in the cycle sclk goes 0->1.
  - On the sclk 1->0 transition, mosi advances to the next bit.
  - After the N-th falling edge -> HOLD; mosi=0.
  - Read-data capture: miso samples for bits ADDR_WIDTH+1..N-1 (0-based) shift into a capture register, MSB first. miso is ignored during command/address bits.
- HOLD lasts CLK_DIV cycles; then cs_n=1 -> GAP.
  - rsp_valid pulses in the cycle cs_n rises.
  - On reads, rsp_rd_data updates in that cycle; on writes, rsp_rd_data holds its previous value.
- GAP lasts CLK_DIV cycles; then req_ready=1, busy=0 -> IDLE.
- Timing totals:
  - cs_n low for exactly CLK_DIV*(2N+2) cycles.
  - Accept-to-rsp_valid = CLK_DIV*(2N+2)+1 cycles.
  - Accept-to-next-accept ≥ CLK_DIV*(2N+3)+1 cycles.
- req_valid while req_ready=0 is ignored. Request inputs are sampled only at accept and may change afterwards.
- Back-to-back: a request held high is accepted in the first cycle req_ready=1, so cs_n stays high for exactly CLK_DIV+1 cycles between frames.
- CLK_DIV=1: sclk toggles every sys_clk cycle; the same rules apply.

Optional Feature:
- Macro SPI_HOST_LOOPBACK_EN.
- Defined: the miso port is ignored. The sample point captures the registered mosi value instead, so reads return the transmitted zeros and write frames echo internally (for bring-up without a DUT). A sticky output lb_mismatch (1 bit, reset 0) sets if mosi changes during any sclk-high phase.
- Undefined: miso is used as specified and lb_mismatch does not exist.

Test Plan:
- ADDR_WIDTH=8, DATA_WIDTH=8, CLK_DIV=2 (N=17). Write addr=0xA5, data=0x3C -> 17 sclk pulses; mosi at rising edges = 0,10100101,00111100; cs_n low 72 cycles; rsp_valid once at cycle 73 after accept.
- Read addr=0x0F with device model driving 0xC3 on data bits -> mosi shows 1,00001111,00000000; rsp_rd_data=0xC3 at rsp_valid.
- Two requests with req_valid held high -> second accepted 75 cycles after the first; cs_n high exactly 3 cycles between frames; the second frame's data is unaffected by the first.
- rst asserted at cycle 30 of a read -> next cycle: cs_n=1, sclk=0, req_ready=1, no rsp_valid; the following read completes normally.
- CLK_DIV=1, read with miso tied 1 -> sclk period 2 cycles, rsp_rd_data=0xFF, rsp_valid 37 cycles after accept.
- SPI_HOST_LOOPBACK_EN defined, read addr=0xFF with miso tied 1 -> rsp_rd_data=0x00, lb_mismatch stays 0.
